// File: rtl/assoc_predictor_v2.sv
// Associativity predictor: a shadow fully-associative LRU directory classifies
// real-cache misses, and per-epoch scores drive step up/down requests to the setup unit.
module assoc_predictor_v2 #(
    parameter int ADDR_BITS       = 32,
    parameter int OFFSET_BITS     = 6,
    parameter int SHADOW_ENTRIES  = 16,
    parameter int SETUP_LEVELS    = 4,
    parameter int EPOCH_LEN       = 64,
    parameter int CNT_BITS        = 8,
    parameter int CONFLICT_WEIGHT = 2,
    parameter int CAPACITY_WEIGHT = 1,
    parameter int UP_THRESH       = 16,
    parameter int DOWN_THRESH     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            acc_valid,
    input  logic [ADDR_BITS-1:0]            acc_addr,
    input  logic                            acc_hit,
    input  logic                            flush,
    input  logic                            setup_ready,
    output logic                            setup_valid,
    output logic                            setup_update,
    output logic [$clog2(SETUP_LEVELS)-1:0] setup_level,
    output logic                            cls_valid,
    output logic [1:0]                      cls_type
);
    localparam int TAG_W = ADDR_BITS - OFFSET_BITS;
    localparam int AGE_W = $clog2(SHADOW_ENTRIES);
    localparam int LVL_W = $clog2(SETUP_LEVELS);
    localparam int EP_W  = $clog2(EPOCH_LEN + 1);
    localparam logic [AGE_W-1:0]    AGE_MAX = AGE_W'(SHADOW_ENTRIES - 1);
    localparam logic [LVL_W-1:0]    LVL_MAX = LVL_W'(SETUP_LEVELS - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    localparam logic [1:0] CLS_HIT = 2'd0, CLS_COMP = 2'd1, CLS_CONF = 2'd2, CLS_CAP = 2'd3;

    logic [SHADOW_ENTRIES-1:0]            ent_valid;
    logic [SHADOW_ENTRIES-1:0][TAG_W-1:0] ent_tag;
    logic [SHADOW_ENTRIES-1:0][AGE_W-1:0] ent_age;
    logic [CNT_BITS-1:0]                  conflict_score, capacity_score;
    logic [EP_W-1:0]                      epoch_cnt;

    logic [TAG_W-1:0] tag;
    logic             unused_offset;
    assign tag           = acc_addr[ADDR_BITS-1:OFFSET_BITS];
    assign unused_offset = ^acc_addr[OFFSET_BITS-1:0];

    logic             sh_hit, sh_full, found_free;
    logic [AGE_W-1:0] hit_idx, victim_idx, hit_age;

    // Victim is the lowest free slot, otherwise the single entry holding the oldest age.
    always_comb begin
        sh_hit     = 1'b0;
        hit_idx    = '0;
        victim_idx = '0;
        found_free = 1'b0;
        for (int i = 0; i < SHADOW_ENTRIES; i++) begin
            if (ent_valid[i] && ent_tag[i] == tag) begin
                sh_hit  = 1'b1;
                hit_idx = AGE_W'(i);
            end
        end
        for (int i = SHADOW_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                found_free = 1'b1;
                victim_idx = AGE_W'(i);
            end
        end
        if (!found_free) begin
            for (int i = 0; i < SHADOW_ENTRIES; i++) begin
                if (ent_age[i] == AGE_MAX) victim_idx = AGE_W'(i);
            end
        end
    end

    assign sh_full = &ent_valid;
    assign hit_age = ent_age[hit_idx];

    logic [1:0] cls_next;
    always_comb begin
        if (acc_hit)      cls_next = CLS_HIT;
        else if (sh_hit)  cls_next = CLS_CONF;
        else if (!sh_full) cls_next = CLS_COMP;
        else              cls_next = CLS_CAP;
    end

    logic [CNT_BITS:0]   conf_sum, cap_sum;
    logic [CNT_BITS-1:0] conf_next, cap_next;
    logic [EP_W-1:0]     epoch_next;
    logic                epoch_end;

    assign conf_sum   = {1'b0, conflict_score} + (CNT_BITS+1)'(CONFLICT_WEIGHT);
    assign cap_sum    = {1'b0, capacity_score} + (CNT_BITS+1)'(CAPACITY_WEIGHT);
    assign conf_next  = (cls_next != CLS_CONF) ? conflict_score :
                        conf_sum[CNT_BITS] ? CNT_MAX : conf_sum[CNT_BITS-1:0];
    assign cap_next   = (cls_next != CLS_CAP) ? capacity_score :
                        cap_sum[CNT_BITS] ? CNT_MAX : cap_sum[CNT_BITS-1:0];
    assign epoch_next = epoch_cnt + EP_W'(1);
    assign epoch_end  = (epoch_next == EP_W'(EPOCH_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid      <= '0;
            ent_tag        <= '0;
            ent_age        <= '0;
            conflict_score <= '0;
            capacity_score <= '0;
            epoch_cnt      <= '0;
            setup_valid    <= 1'b0;
            setup_update   <= 1'b0;
            setup_level    <= '0;
            cls_valid      <= 1'b0;
            cls_type       <= CLS_HIT;
        end else begin
            cls_valid <= acc_valid;
            cls_type  <= acc_valid ? cls_next : CLS_HIT;

            if (setup_valid && setup_ready) begin
                setup_valid <= 1'b0;
                setup_level <= setup_update ? setup_level + LVL_W'(1) : setup_level - LVL_W'(1);
            end

            if (flush) begin
                ent_valid      <= '0;
                conflict_score <= '0;
                capacity_score <= '0;
                epoch_cnt      <= '0;
            end else if (acc_valid) begin
                for (int i = 0; i < SHADOW_ENTRIES; i++) begin
                    if (sh_hit) begin
                        if (AGE_W'(i) == hit_idx)
                            ent_age[i] <= '0;
                        else if (ent_valid[i] && ent_age[i] < hit_age)
                            ent_age[i] <= ent_age[i] + AGE_W'(1);
                    end else if (AGE_W'(i) == victim_idx) begin
                        ent_valid[i] <= 1'b1;
                        ent_tag[i]   <= tag;
                        ent_age[i]   <= '0;
                    end else if (ent_valid[i] && ent_age[i] != AGE_MAX) begin
                        ent_age[i] <= ent_age[i] + AGE_W'(1);
                    end
                end

                // Scores and epoch hold still while a request waits for the setup unit.
                if (!setup_valid) begin
                    if (epoch_end) begin
                        conflict_score <= '0;
                        capacity_score <= '0;
                        epoch_cnt      <= '0;
                        if (conf_next >= CNT_BITS'(UP_THRESH) && setup_level != LVL_MAX) begin
                            setup_valid  <= 1'b1;
                            setup_update <= 1'b1;
                        end else if (cap_next >= CNT_BITS'(DOWN_THRESH) && setup_level != '0) begin
                            setup_valid  <= 1'b1;
                            setup_update <= 1'b0;
                        end
                    end else begin
                        conflict_score <= conf_next;
                        capacity_score <= cap_next;
                        epoch_cnt      <= epoch_next;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_assoc_predictor_v2.sv
// Scoreboard bench for assoc_predictor_v2: a recency-list reference model predicts
// classifications and the request/level handshake cycle by cycle.
module tb_assoc_predictor_v2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acc_valid = 1'b0, acc_hit = 1'b0, flush = 1'b0, setup_ready = 1'b0;
    logic [31:0] acc_addr = '0;
    logic        setup_valid, setup_update, cls_valid;
    logic [1:0]  setup_level, cls_type;

    logic        s_valid = 1'b0;
    logic [31:0] s_addr = '0;
    logic        s_setup_valid, s_setup_update, s_cls_valid;
    logic [1:0]  s_setup_level, s_cls_type;

    always #5 clk = ~clk;

    assoc_predictor_v2 #(
        .SHADOW_ENTRIES(4), .EPOCH_LEN(8), .UP_THRESH(4), .DOWN_THRESH(4)
    ) dut (
        .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_addr(acc_addr),
        .acc_hit(acc_hit), .flush(flush), .setup_ready(setup_ready),
        .setup_valid(setup_valid), .setup_update(setup_update),
        .setup_level(setup_level), .cls_valid(cls_valid), .cls_type(cls_type)
    );

    // Narrow counters: 6 conflicts x 2 would wrap to 4 without saturation.
    assoc_predictor_v2 #(
        .SHADOW_ENTRIES(2), .EPOCH_LEN(8), .CNT_BITS(3), .UP_THRESH(6), .DOWN_THRESH(6)
    ) u_sat (
        .clk(clk), .rst(rst), .acc_valid(s_valid), .acc_addr(s_addr),
        .acc_hit(1'b0), .flush(1'b0), .setup_ready(1'b0),
        .setup_valid(s_setup_valid), .setup_update(s_setup_update),
        .setup_level(s_setup_level), .cls_valid(s_cls_valid), .cls_type(s_cls_type)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    int lru[$];
    int cls_q[$];
    int m_conf = 0, m_cap = 0, m_epoch = 0, m_level = 0;
    bit m_pend = 0, m_upd = 0;

    task automatic cyc(input bit v, input int addr, input bit hit, input bit fl, input bit rdy);
        int t, pos, c;
        bit old_pend;
        t = addr >> 6;
        old_pend = m_pend;
        acc_valid = v; acc_addr = addr; acc_hit = hit; flush = fl; setup_ready = rdy;
        if (v) begin
            pos = -1;
            foreach (lru[i]) if (lru[i] == t) pos = i;
            c = hit ? 0 : (pos >= 0 ? 2 : (lru.size() < 4 ? 1 : 3));
            cls_q.push_back(c);
            if (!fl) begin
                if (pos >= 0) lru.delete(pos);
                else if (lru.size() == 4) void'(lru.pop_back());
                lru.push_front(t);
                if (!old_pend) begin
                    m_epoch++;
                    if (c == 2) m_conf = (m_conf + 2 > 255) ? 255 : m_conf + 2;
                    if (c == 3) m_cap = (m_cap + 1 > 255) ? 255 : m_cap + 1;
                    if (m_epoch == 8) begin
                        if (m_conf >= 4 && m_level < 3) begin m_pend = 1; m_upd = 1; end
                        else if (m_cap >= 4 && m_level > 0) begin m_pend = 1; m_upd = 0; end
                        m_conf = 0; m_cap = 0; m_epoch = 0;
                    end
                end
            end
        end
        if (fl) begin
            lru.delete();
            m_conf = 0; m_cap = 0; m_epoch = 0;
        end
        if (old_pend && rdy) begin
            m_level = m_upd ? m_level + 1 : m_level - 1;
            m_pend = 0;
        end
        @(posedge clk); #1;
        chk("cls_valid", cls_valid, v);
        if (cls_q.size() > 0) begin
            c = cls_q.pop_front();
            if (cls_valid) chk("cls_type", cls_type, c);
        end
        chk("setup_valid", setup_valid, m_pend);
        if (m_pend) chk("setup_update", setup_update, m_upd);
        chk("setup_level", setup_level, m_level);
    endtask

    task automatic acc(input int addr, input bit hit = 0);
        cyc(1, addr, hit, 0, 0);
    endtask

    task automatic reset_dut();
        rst = 1; acc_valid = 0; flush = 0; setup_ready = 0; acc_hit = 0; s_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        lru.delete(); cls_q.delete();
        m_conf = 0; m_cap = 0; m_epoch = 0; m_level = 0; m_pend = 0; m_upd = 0;
        chk("rst_setup_valid", setup_valid, 0);
        chk("rst_setup_update", setup_update, 0);
        chk("rst_setup_level", setup_level, 0);
        chk("rst_cls_valid", cls_valid, 0);
        chk("rst_cls_type", cls_type, 0);
        rst = 0;
    endtask

    // Four compulsory misses then four re-misses: conflict score 8.
    task automatic up_round();
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) acc((i % 4) * 64);
    endtask

    // Four compulsory misses then four capacity misses over five tags.
    task automatic cap_round();
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) acc(i * 64);
        acc('h100); acc('h000); acc('h040); acc('h080);
    endtask

    initial begin
        reset_dut();

        // conflict up, held for 5 cycles with accesses, then accepted
        for (int i = 0; i < 8; i++) acc((i % 4) * 64);
        for (int i = 0; i < 5; i++) acc(i * 64);
        cyc(0, 0, 0, 0, 1);

        // LRU eviction; ready while idle must be ignored
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) acc(i * 64);
        acc('h000, 1);
        acc('h100); acc('h040); acc('h000);
        cyc(0, 0, 0, 0, 1);

        // capacity down from level 1
        cap_round();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);

        // level 0 with only capacity: no request
        cap_round();
        cyc(0, 0, 0, 0, 1);

        // climb to level 3, then a conflict epoch must not request
        for (int r = 0; r < 3; r++) begin
            up_round();
            cyc(0, 0, 0, 0, 1);
        end
        up_round();
        cyc(0, 0, 0, 0, 1);
        chk("lvl3_no_req", setup_valid, 0);

        // flush while pending keeps the request; flush+access classified pre-flush
        cap_round();
        cyc(0, 0, 0, 1, 0);
        acc('h000);
        cyc(1, 'h000, 0, 1, 0);
        acc('h000);
        chk("flush_keeps_req", setup_valid, 1);

        // reset while pending drops the request
        reset_dut();

        // saturating score on the narrow instance
        for (int i = 0; i < 8; i++) begin
            s_valid = 1; s_addr = (i % 2) * 64;
            cyc(0, 0, 0, 0, 0);
            if (i < 7) chk("sat_idle", s_setup_valid, 0);
        end
        s_valid = 0;
        chk("sat_up_valid", s_setup_valid, 1);
        chk("sat_up_update", s_setup_update, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/assoc_predictor_v2.md
Name: assoc_predictor_v2

Overview:
Parametrised associativity predictor for the mutative cache. It keeps a shadow fully-associative LRU tag directory and classifies every real-cache miss as compulsory, conflict or capacity. Per fixed-length epoch it accumulates weighted conflict and capacity scores, then requests a step up or down in cache associativity level over a valid/ready handshake. It sits beside the cache controller and feeds the setup/reconfiguration unit.

Parameters:
ADDR_BITS, 32, request address width
OFFSET_BITS, 6, line offset bits; tag = addr >> OFFSET_BITS
SHADOW_ENTRIES, 16, shadow directory entries (power of 2, >=2)
SETUP_LEVELS, 4, number of associativity levels (>=2)
EPOCH_LEN, 64, accesses per evaluation epoch
CNT_BITS, 8, score counter width (saturating)
CONFLICT_WEIGHT, 2, score added per conflict miss
CAPACITY_WEIGHT, 1, score added per capacity miss
UP_THRESH, 16, conflict score needed to request up
DOWN_THRESH, 16, capacity score needed to request down

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
acc_valid  in  1  one completed cache access this cycle
acc_addr  in  ADDR_BITS  access byte address
acc_hit  in  1  real cache hit for this access
flush  in  1  clear shadow directory, scores and epoch count
setup_ready  in  1  setup unit accepts request
setup_valid  out  1  level-change request pending
setup_update  out  1  1 = step up, 0 = step down; stable while setup_valid
setup_level  out  $clog2(SETUP_LEVELS)  current level
cls_valid  out  1  classification result valid
cls_type  out  2  0 hit, 1 compulsory, 2 conflict, 3 capacity

Behaviour:
- Reset clears all shadow entries and scores, epoch count = 0, setup_level = 0. All outputs read 0 in the first cycle after reset. Reset during a pending request drops the request.
- Shadow lookup on acc_valid is combinational against the current state. tag = acc_addr[ADDR_BITS-1:OFFSET_BITS]. Shadow state updates at the same edge.
- Classification, registered with 1-cycle latency (cls_valid/cls_type appear the cycle after acc_valid):
  - acc_hit=1 -> hit.
  - Miss and shadow hit -> conflict.
  - Miss, shadow miss, shadow not full -> compulsory.
  - Miss, shadow miss, shadow full -> capacity.
- Shadow update on every acc_valid, whether hit or miss:
  - Shadow hit: entry age -> 0; valid entries with age below the old age increment.
  - Shadow miss: allocate the lowest-index invalid entry, else the entry with age SHADOW_ENTRIES-1. New entry gets age 0; all other valid entries increment (saturate at SHADOW_ENTRIES-1).
- Ages of valid entries always form a permutation of 0..n-1.
- Scores: conflict_score += CONFLICT_WEIGHT; capacity_score += CAPACITY_WEIGHT. Both saturate at 2^CNT_BITS-1. Compulsory misses and hits add nothing.
- Epoch: the counter increments on each acc_valid while no request is pending. When the access that makes the count EPOCH_LEN is counted, evaluate on the post-update scores:
  - conflict_score >= UP_THRESH and setup_level < SETUP_LEVELS-1 -> raise request, update=1.
  - Else capacity_score >= DOWN_THRESH and setup_level > 0 -> raise request, update=0.
  - In all cases clear both scores and the epoch count.
- Up takes priority when both thresholds are met.
- Handshake: setup_valid rises the cycle after evaluation and holds, with setup_update stable, until sampled with setup_ready=1. At that edge setup_level +/-1 and setup_valid falls. setup_ready while idle is ignored.
- While a request is pending:
  - Shadow updates and classification continue.
  - Scores and the epoch count are frozen.
- flush:
  - Invalidates all shadow entries and clears scores and the epoch count.
  - A pending request and setup_level are kept.
  - flush with acc_valid in the same cycle: flush wins; the access is still classified against the pre-flush state, but not recorded in the shadow or scores.

Test Plan:
Parameters for all scenarios: SHADOW_ENTRIES=4, EPOCH_LEN=8, UP_THRESH=4, DOWN_THRESH=4, OFFSET_BITS=6, both weights default.
1. Reset: assert rst 2 cycles -> setup_valid=0, setup_level=0, cls_valid=0.
2. Conflict up:
   - Misses 0x000,0x040,0x080,0x0C0 -> cls_type=1 x4.
   - Re-miss the same 4 addresses -> cls_type=2 x4, conflict_score=8.
   - Next cycle setup_valid=1, update=1.
   - Hold setup_ready=0 for 5 cycles -> request held, epoch frozen.
   - setup_ready=1 -> setup_level=1, setup_valid=0.
3. LRU eviction:
   - From empty, miss 0x000..0x0C0, then hit 0x000.
   - Miss 0x100 -> cls_type=3, evicts 0x040.
   - Miss 0x040 -> cls_type=3; miss 0x000 -> cls_type=2.
4. Capacity down:
   - At level 1, from empty, 4 compulsory misses, then 4 misses cycling through 5 distinct tags -> capacity_score=4.
   - setup_valid=1, update=0; after setup_ready, setup_level=0.
5. Boundaries:
   - At level 3 with conflict_score>=4 at epoch end -> no request, scores cleared.
   - At level 0 with only capacity -> no request.
   - Score saturates at 255 with CNT_BITS=8, EPOCH_LEN large.
6. Flush/reset mid-pending:
   - flush while setup_valid=1 -> request kept; next access to 0x000 -> cls_type=1.
   - rst while setup_valid=1 -> setup_valid=0 next cycle.
